// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: two debounced buttons drive a colour-mode FSM and a brightness level into a PWM stage.
// Optional AUTO colour-cycling mode is built only when RGB_LED_SEQ_AUTO_EN is defined.
module rgb_led_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_BITS        = 8,
    parameter int STEP_CYCLES     = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_button0,
    input  logic       push_button1,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue,
    output logic [2:0] mode,
    output logic [1:0] level
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]     DB_ONE   = DB_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    if (DEBOUNCE_CYCLES < 2 || PWM_BITS < 4 || PWM_BITS > 16 || STEP_CYCLES < 2) begin : g_bad_params
        $error("rgb_led_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_RED   = 3'd1,
        MODE_GREEN = 3'd2,
        MODE_BLUE  = 3'd3,
        MODE_WHITE = 3'd4
`ifdef RGB_LED_SEQ_AUTO_EN
        , MODE_AUTO = 3'd5
`endif
    } mode_t;

    logic [1:0] raw;
    logic [1:0] press;
    assign raw = {push_button1, push_button0};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_btn
        logic            sync1_reg, sync2_reg, stable_reg, press_reg;
        logic [DB_W-1:0] count_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync1_reg  <= 1'b0;
                sync2_reg  <= 1'b0;
                stable_reg <= 1'b0;
                press_reg  <= 1'b0;
                count_reg  <= '0;
            end else begin
                sync1_reg <= raw[gi];
                sync2_reg <= sync1_reg;
                press_reg <= 1'b0;
                if (sync2_reg == stable_reg) begin
                    count_reg <= '0;
                end else if (count_reg == DB_LAST) begin
                    // Level accepted; only a rising acceptance is a press event.
                    count_reg  <= '0;
                    stable_reg <= sync2_reg;
                    press_reg  <= sync2_reg;
                end else begin
                    count_reg <= count_reg + DB_ONE;
                end
            end
        end

        assign press[gi] = press_reg;
    end

    mode_t      mode_reg, mode_next;
    logic [1:0] level_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_reg  <= MODE_OFF;
            level_reg <= 2'd3;
        end else begin
            mode_reg  <= mode_next;
            level_reg <= level_reg + {1'b0, press[1]};
        end
    end

    always_comb begin
        mode_next = mode_reg;
        if (press[0]) begin
            case (mode_reg)
                MODE_OFF:   mode_next = MODE_RED;
                MODE_RED:   mode_next = MODE_GREEN;
                MODE_GREEN: mode_next = MODE_BLUE;
                MODE_BLUE:  mode_next = MODE_WHITE;
`ifdef RGB_LED_SEQ_AUTO_EN
                MODE_WHITE: mode_next = MODE_AUTO;
`else
                MODE_WHITE: mode_next = MODE_OFF;
`endif
                default:    mode_next = MODE_OFF;
            endcase
        end
    end

    logic [2:0] mask_now;

`ifdef RGB_LED_SEQ_AUTO_EN
    logic [STEP_W-1:0] dwell_reg;
    logic [1:0]        auto_idx_reg;

    // Held at zero outside AUTO, so every entry restarts at red with a fresh dwell.
    always_ff @(posedge clock) begin
        if (reset || mode_reg != MODE_AUTO) begin
            dwell_reg    <= '0;
            auto_idx_reg <= 2'd0;
        end else if (dwell_reg == STEP_W'(STEP_CYCLES - 1)) begin
            dwell_reg    <= '0;
            auto_idx_reg <= (auto_idx_reg == 2'd2) ? 2'd0 : auto_idx_reg + 2'd1;
        end else begin
            dwell_reg <= dwell_reg + STEP_W'(1);
        end
    end
`endif

    always_comb begin
        mask_now = 3'b000;
        case (mode_reg)
            MODE_RED:   mask_now = 3'b100;
            MODE_GREEN: mask_now = 3'b010;
            MODE_BLUE:  mask_now = 3'b001;
            MODE_WHITE: mask_now = 3'b111;
`ifdef RGB_LED_SEQ_AUTO_EN
            MODE_AUTO:  mask_now = 3'b100 >> auto_idx_reg;
`endif
            default:    mask_now = 3'b000;
        endcase
    end

    // (2^N >> s) - 1 equals (2^N - 1) >> s, which avoids a wider intermediate.
    logic [PWM_BITS-1:0] duty_now, duty_eff, duty_lat_reg, pwm_cnt_reg;
    logic [2:0]          mask_eff, mask_lat_reg, led_next, led_reg;

    assign duty_now = DUTY_MAX >> (2'd3 - level_reg);
    assign duty_eff = (pwm_cnt_reg == '0) ? duty_now : duty_lat_reg;
    assign mask_eff = (pwm_cnt_reg == '0) ? mask_now : mask_lat_reg;

    for (gi = 0; gi < 3; gi++) begin : g_chan
        assign led_next[gi] = mask_eff[gi] && (pwm_cnt_reg < duty_eff);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt_reg  <= '0;
            duty_lat_reg <= '0;
            mask_lat_reg <= 3'b000;
            led_reg      <= 3'b000;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_ONE;
            if (pwm_cnt_reg == '0) begin
                duty_lat_reg <= duty_now;
                mask_lat_reg <= mask_now;
            end
            led_reg <= led_next;
        end
    end

    assign led_red   = led_reg[2];
    assign led_green = led_reg[1];
    assign led_blue  = led_reg[0];
    assign mode      = mode_reg;
    assign level     = level_reg;
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: directed test-plan scenarios plus random button traffic, all
// outputs compared every cycle against a cycle-count based behavioural model.
module tb_rgb_led_sequencer;
    localparam int D    = 4;
    localparam int PB   = 4;
    localparam int STEP = 32;
    localparam int PER  = 1 << PB;
`ifdef RGB_LED_SEQ_AUTO_EN
    localparam int LAST_MODE = 5;
`else
    localparam int LAST_MODE = 4;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pb0 = 1'b0, pb1 = 1'b0;
    logic       led_red, led_green, led_blue;
    logic [2:0] mode;
    logic [1:0] level;

    rgb_led_sequencer #(.DEBOUNCE_CYCLES(D), .PWM_BITS(PB), .STEP_CYCLES(STEP)) dut (
        .clock(clock), .reset(reset), .push_button0(pb0), .push_button1(pb1),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
        .mode(mode), .level(level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    // Model: debounce as a run-length of disagreeing synchronised samples, PWM phase as a
    // cycle count since reset, AUTO colour as elapsed cycles since entry divided by STEP.
    bit model_on = 0;
    int m_mode, m_level, m_pwm, m_age, m_lat_mask, m_lat_duty, m_led;
    bit m_press [2];
    bit s1 [2], s2 [2], st [2];
    int run [2];
    bit raw_now [2];

    function automatic int mask_of(input int md, input int age);
        case (md)
            1: return 4;
            2: return 2;
            3: return 1;
            4: return 7;
            5: return 4 >> ((age / STEP) % 3);
            default: return 0;
        endcase
    endfunction

    always @(posedge clock) begin
        raw_now[0] = pb0;
        raw_now[1] = pb1;
        if (reset) begin
            model_on = 1;
            m_mode = 0; m_level = 3; m_pwm = 0; m_age = 0;
            m_lat_mask = 0; m_lat_duty = 0; m_led = 0;
            for (int i = 0; i < 2; i++) begin
                m_press[i] = 0; s1[i] = 0; s2[i] = 0; st[i] = 0; run[i] = 0;
            end
        end else begin
            if (m_pwm == 0) begin
                m_lat_mask = mask_of(m_mode, m_age);
                m_lat_duty = (PER >> (3 - m_level)) - 1;
            end
            m_led = (m_pwm < m_lat_duty) ? m_lat_mask : 0;
            if (m_press[1]) m_level = (m_level + 1) % 4;
            if (m_press[0]) begin
                m_mode = (m_mode == LAST_MODE) ? 0 : m_mode + 1;
                m_age = 0;
            end else if (m_mode == 5) begin
                m_age++;
            end
            for (int i = 0; i < 2; i++) begin
                m_press[i] = 0;
                if (s2[i] != st[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        st[i] = s2[i];
                        run[i] = 0;
                        m_press[i] = s2[i];
                    end
                end else begin
                    run[i] = 0;
                end
                s2[i] = s1[i];
                s1[i] = raw_now[i];
            end
            m_pwm = (m_pwm + 1) % PER;
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            logic [7:0] act, exp;
            act = {mode, level, led_red, led_green, led_blue};
            exp = {3'(m_mode), 2'(m_level), 3'(m_led)};
            checks++;
            if (act !== exp) begin
                errors++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL model_cycle t=%0t got mode/level/rgb=%b want %b", $time, act, exp);
                end
            end
        end
    end

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic count_high(output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        repeat (PER) begin
            @(negedge clock);
            r += int'(led_red);
            g += int'(led_green);
            b += int'(led_blue);
        end
    endtask

    task automatic press_btn(input int which);
        if (which == 0) pb0 = 1'b1; else pb1 = 1'b1;
        repeat (D + 6) @(negedge clock);
        pb0 = 1'b0;
        pb1 = 1'b0;
        repeat (D + 6) @(negedge clock);
    endtask

    function automatic int packed_state();
        return int'({led_red, led_green, led_blue, mode, level});
    endfunction

    initial begin
        int r, g, b, first, hold;

        // Reset held with buttons toggling: dark LEDs, mode 0, level 3 (packed value 3).
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            expect_eq("reset_hold", packed_state(), 3);
            pb0 = ~pb0;
            pb1 = (i % 2 == 0);
        end
        reset = 1'b0; pb0 = 1'b0; pb1 = 1'b0;
        @(negedge clock);
        expect_eq("after_reset", packed_state(), 3);

        // A 3-cycle bounce is ignored; a held press lands 7 cycles after the rise.
        pb0 = 1'b1;
        repeat (3) @(negedge clock);
        pb0 = 1'b0;
        repeat (8) @(negedge clock);
        expect_eq("bounce_ignored", int'(mode), 0);
        pb0 = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (first == 0 && mode == 3'd1) first = k;
        end
        expect_eq("press_latency", first, 7);
        pb0 = 1'b0;
        repeat (10) @(negedge clock);
        expect_eq("release_no_event", int'(mode), 1);

        // Duty at level 3 and level 0 in RED.
        repeat (20) @(negedge clock);
        count_high(r, g, b);
        expect_eq("red_high_l3", r, 15);
        expect_eq("gb_high_l3", g + b, 0);
        press_btn(1);
        expect_eq("level_wrap", int'(level), 0);
        repeat (20) @(negedge clock);
        count_high(r, g, b);
        expect_eq("red_high_l0", r, 1);
        expect_eq("gb_high_l0", g + b, 0);

        // Step level 3->0 when the PWM counter is at 5: this period stays at 15, next is 1.
        repeat (3) press_btn(1);
        expect_eq("level_back_3", int'(level), 3);
        repeat (20) @(negedge clock);
        for (int k = 0; k < 2 * PER && m_pwm != 15; k++) @(negedge clock);
        pb1 = 1'b1;
        @(negedge clock);
        count_high(r, g, b);
        expect_eq("latch_current_period", r, 15);
        count_high(r, g, b);
        expect_eq("latch_next_period", r, 1);
        pb1 = 1'b0;
        repeat (12) @(negedge clock);

        // Simultaneous presses from OFF / level 3.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pb0 = 1'b1; pb1 = 1'b1;
        repeat (6) @(negedge clock);
        expect_eq("simul_before", int'(mode), 0);
        @(negedge clock);
        expect_eq("simul_mode", int'(mode), 1);
        expect_eq("simul_level", int'(level), 0);
        pb0 = 1'b0; pb1 = 1'b0;
        repeat (12) @(negedge clock);

        // Walk to WHITE, then the next press goes to AUTO or wraps to OFF.
        repeat (3) press_btn(0);
        expect_eq("mode_white", int'(mode), 4);
        press_btn(1); press_btn(1); press_btn(1);
        press_btn(0);
`ifdef RGB_LED_SEQ_AUTO_EN
        expect_eq("mode_auto", int'(mode), 5);
        repeat (3 * STEP + 20) @(negedge clock);
        press_btn(0);
        expect_eq("auto_to_off", int'(mode), 0);
        repeat (PER) @(negedge clock);
        count_high(r, g, b);
        expect_eq("dark_after_auto", r + g + b, 0);
`else
        expect_eq("white_to_off", int'(mode), 0);
`endif

        // Random button traffic with occasional mid-operation resets.
        for (int n = 0; n < 200; n++) begin
            pb0 = 1'($urandom_range(0, 1));
            pb1 = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 3 * D);
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            repeat (hold) @(negedge clock);
        end
        pb0 = 1'b0; pb1 = 1'b0;
        repeat (3 * PER) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
